dmem_port_arbiter: RTL

//  Shares the single data-memory port between the CPU requesters: GPR X/Y, ACC (STA/LDA),
//  PC stack (PUSH/POP) and the crypto block result/operand path. Round-robin arbitration,
//  one transaction in flight. Sits between the control-unit-driven requesters and data_mem.

---
 rtl/dmem_port_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing the single data-memory port between the CPU requesters.
// One transaction in flight; every output is registered.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transaction in flight; req sampled on every edge
// ST_ISSUE | memory acts on mem_* this cycle; writes finish at next edge
// ST_WAIT  | read data arrives on mem_rdata; captured into rdata at next edge
module dmem_port_arbiter #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          req_we,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_wdata,
   output logic [N_REQ-1:0]          gnt,
   output logic [N_REQ-1:0]          done,
   output logic [DATA_W-1:0]         rdata,
   output logic                      busy,
   output logic                      mem_en,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]    win_q, win_d;
   logic                wr_q, wr_d;
   logic [N_REQ-1:0]    gnt_q, gnt_d;
   logic [N_REQ-1:0]    done_q, done_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                busy_q, busy_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

   logic                found;
   logic [PTR_W-1:0]    pick;
   logic [PTR_W-1:0]    pick_inc;

   // first set request at or after rr_ptr, wrapping modulo N_REQ
   always_comb begin
      found = 1'b0;
      pick  = rr_ptr_q;
      for (int k = 0; k < N_REQ; k++) begin
         int idx;
         idx = (int'(rr_ptr_q) + k) % N_REQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = PTR_W'(idx);
         end
      end
      pick_inc = (int'(pick) == N_REQ - 1) ? '0 : pick + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         win_q       <= '0;
         wr_q        <= 1'b0;
         gnt_q       <= '0;
         done_q      <= '0;
         rdata_q     <= '0;
         busy_q      <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         win_q       <= win_d;
         wr_q        <= wr_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         rdata_q     <= rdata_d;
         busy_q      <= busy_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      win_d    = win_q;
      wr_d     = wr_q;
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               state_d  = ST_ISSUE;
               rr_ptr_d = pick_inc;
               win_d    = pick;
               wr_d     = req_we[pick];
            end
         end
         ST_ISSUE: state_d = wr_q ? ST_IDLE : ST_WAIT;
         ST_WAIT:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // next values of the registered outputs; mem_addr/mem_wdata/rdata hold between updates
   always_comb begin
      gnt_d       = '0;
      done_d      = '0;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               gnt_d       = N_REQ'(1) << pick;
               mem_en_d    = 1'b1;
               mem_we_d    = req_we[pick];
               mem_addr_d  = req_addr[int'(pick)*ADDR_W +: ADDR_W];
               mem_wdata_d = req_wdata[int'(pick)*DATA_W +: DATA_W];
            end
         end
         ST_ISSUE: begin
            if (wr_q) done_d = N_REQ'(1) << win_q;
         end
         ST_WAIT: begin
            done_d  = N_REQ'(1) << win_q;
            rdata_d = mem_rdata;
         end
         default: ;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   assign gnt       = gnt_q;
   assign done      = done_q;
   assign rdata     = rdata_q;
   assign busy      = busy_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule
